// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch sequencer: one outstanding fetch over req/ack,
// a single-entry instruction buffer, execute-stage redirects and misaligned-target traps.
module pc_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] INITPC    = {XLEN{1'b0}},
    parameter int              IMM_SHIFT = 0
) (
    input  logic            clk,
    input  logic            nRST,
    output logic            fetch_req,
    output logic [XLEN-1:0] fetch_addr,
    input  logic            fetch_ack,
    input  logic [31:0]     fetch_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            halt,
    input  logic            br_valid,
    input  logic [2:0]      br_op,
    input  logic            br_eq,
    input  logic            br_lt,
    input  logic            br_ltu,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_base,
    input  logic [XLEN-1:0] br_offset,
    output logic            redirect,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_addr
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_TRAPPED = 2'd2
    } state_t;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_JAL  = 3'd2;
    localparam logic [2:0] BR_JALR = 3'd3;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic            kill_r, kill_nxt_s;
    logic            fetch_req_r, req_nxt_s;
    logic [XLEN-1:0] fetch_addr_r, fetch_addr_nxt_s;
    logic            instr_valid_r, ivalid_nxt_s;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] instr_pc_r;
    logic            redirect_r, trap_valid_r;
    logic [XLEN-1:0] trap_addr_r;

    logic            taken_s;
    logic [XLEN-1:0] offset_sh_s, jalr_sum_s, target_s;
    logic            br_hit_s, do_trap_s, do_redir_s;
    logic            ack_s, load_instr_s, in_flight_s;

    // Branch condition decode from the execute-stage compare flags.
    always_comb begin
        taken_s = 1'b0;
        case (br_op)
            BR_BEQ:  taken_s = br_eq;
            BR_BNE:  taken_s = ~br_eq;
            BR_BLT:  taken_s = br_lt;
            BR_BGE:  taken_s = ~br_lt;
            BR_BLTU: taken_s = br_ltu;
            BR_BGEU: taken_s = ~br_ltu;
            BR_JAL:  taken_s = 1'b1;
            BR_JALR: taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
    end

    // Target address; JALR clears bit 0 of the computed sum.
    always_comb begin
        offset_sh_s = br_offset << IMM_SHIFT;
        jalr_sum_s  = br_base + offset_sh_s;
        if (br_op == BR_JALR) begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = br_pc + offset_sh_s;
        end
    end

    assign br_hit_s    = br_valid & taken_s & (state_r != ST_TRAPPED);
    assign do_trap_s   = br_hit_s & (target_s[1:0] != 2'b00);
    assign do_redir_s  = br_hit_s & (target_s[1:0] == 2'b00);
    assign ack_s       = fetch_req_r & fetch_ack;
    assign in_flight_s = fetch_req_r & ~fetch_ack;

    // Next-state logic; a resolved control transfer overrides normal sequencing.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        kill_nxt_s   = kill_r;
        ivalid_nxt_s = instr_valid_r;
        load_instr_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (ack_s) begin
                    if (kill_r) begin
                        kill_nxt_s = 1'b0;
                    end else begin
                        load_instr_s = 1'b1;
                        ivalid_nxt_s = 1'b1;
                        pc_nxt_s     = pc_r + PC_STEP;
                        state_nxt_s  = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (instr_valid_r && instr_ready) begin
                    ivalid_nxt_s = 1'b0;
                    state_nxt_s  = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_TRAPPED: begin
                state_nxt_s = ST_TRAPPED;
            end
            default: begin
                state_nxt_s = ST_TRAPPED;
            end
        endcase

        if (do_trap_s) begin
            load_instr_s = 1'b0;
            ivalid_nxt_s = 1'b0;
            pc_nxt_s     = pc_r;
            kill_nxt_s   = 1'b0;
            state_nxt_s  = ST_TRAPPED;
        end else if (do_redir_s) begin
            load_instr_s = 1'b0;
            ivalid_nxt_s = 1'b0;
            pc_nxt_s     = target_s;
            kill_nxt_s   = in_flight_s;
            state_nxt_s  = ST_FETCH;
        end else begin
            load_instr_s = load_instr_s;
        end
    end

    // Request and address: an unacked request is held with its original address.
    always_comb begin
        if (in_flight_s) begin
            req_nxt_s        = 1'b1;
            fetch_addr_nxt_s = fetch_addr_r;
        end else if ((state_nxt_s == ST_FETCH) && !halt) begin
            req_nxt_s        = 1'b1;
            fetch_addr_nxt_s = pc_nxt_s;
        end else begin
            req_nxt_s        = 1'b0;
            fetch_addr_nxt_s = pc_nxt_s;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r       <= ST_FETCH;
            pc_r          <= INITPC;
            kill_r        <= 1'b0;
            fetch_req_r   <= 1'b0;
            fetch_addr_r  <= INITPC;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= {XLEN{1'b0}};
            redirect_r    <= 1'b0;
            trap_valid_r  <= 1'b0;
            trap_addr_r   <= {XLEN{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            kill_r        <= kill_nxt_s;
            fetch_req_r   <= req_nxt_s;
            fetch_addr_r  <= fetch_addr_nxt_s;
            instr_valid_r <= ivalid_nxt_s;
            redirect_r    <= do_redir_s;
            trap_valid_r  <= do_trap_s;
            if (load_instr_s) begin
                instr_r    <= fetch_data;
                instr_pc_r <= pc_r;
            end else begin
                instr_r    <= instr_r;
                instr_pc_r <= instr_pc_r;
            end
            if (do_trap_s) begin
                trap_addr_r <= target_s;
            end else begin
                trap_addr_r <= trap_addr_r;
            end
        end
    end

    assign fetch_req   = fetch_req_r;
    assign fetch_addr  = fetch_addr_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign redirect    = redirect_r;
    assign trap_valid  = trap_valid_r;
    assign trap_addr   = trap_addr_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with INITPC = 0x100.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        nRST;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halt;
    logic        br_valid;
    logic [2:0]  br_op;
    logic        br_eq, br_lt, br_ltu;
    logic [31:0] br_pc, br_base, br_offset;
    logic        redirect;
    logic        trap_valid;
    logic [31:0] trap_addr;

    int num_checks = 0;
    int num_errors = 0;

    pc_fetch_unit #(.XLEN(32), .INITPC(32'h0000_0100), .IMM_SHIFT(0)) dut (
        .clk(clk), .nRST(nRST),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halt(halt),
        .br_valid(br_valid), .br_op(br_op), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .br_pc(br_pc), .br_base(br_base), .br_offset(br_offset),
        .redirect(redirect), .trap_valid(trap_valid), .trap_addr(trap_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_val("req_seen", 32'(fetch_req), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        wait_req();
        check_val("fetch_addr", fetch_addr, addr);
        tick();
        check_val("req_held", 32'(fetch_req), 32'd1);
        fetch_ack  = 1'b1;
        fetch_data = data;
        tick();
        fetch_ack  = 1'b0;
        check_val("instr_valid", 32'(instr_valid), 32'd1);
        check_val("instr", instr, data);
        check_val("instr_pc", instr_pc, addr);
    endtask

    task automatic br(input logic [2:0] op, input logic eq, input logic lt, input logic ltu,
                      input logic [31:0] pc, input logic [31:0] base, input logic [31:0] off);
        br_valid  = 1'b1;
        br_op     = op;
        br_eq     = eq;
        br_lt     = lt;
        br_ltu    = ltu;
        br_pc     = pc;
        br_base   = base;
        br_offset = off;
        tick();
        br_valid  = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; fetch_ack = 1'b0; fetch_data = 32'h0; instr_ready = 1'b1; halt = 1'b0;
        br_valid = 1'b0; br_op = 3'd0; br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        br_pc = 32'h0; br_base = 32'h0; br_offset = 32'h0;
        #12;
        check_val("rst_req", 32'(fetch_req), 32'd0);
        check_val("rst_ivalid", 32'(instr_valid), 32'd0);
        check_val("rst_redirect", 32'(redirect), 32'd0);
        check_val("rst_trap", 32'(trap_valid), 32'd0);
        check_val("rst_addr", fetch_addr, 32'h100);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_ipc", instr_pc, 32'h0);
        check_val("rst_trap_addr", trap_addr, 32'h0);
        tick();
        nRST = 1'b1;
        tick();
        check_val("req_after_rst", 32'(fetch_req), 32'd1);

        // Sequential fetch 100, 104 (held in buffer), 108
        do_fetch(32'h100, 32'h0000_0013);
        tick();
        wait_req();
        check_val("fetch_addr_104", fetch_addr, 32'h104);
        tick();
        instr_ready = 1'b0;
        fetch_ack = 1'b1; fetch_data = 32'h0010_0093;
        tick();
        fetch_ack = 1'b0;
        check_val("ivalid_104", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("hold_ivalid", 32'(instr_valid), 32'd1);
            check_val("hold_ipc", instr_pc, 32'h104);
            check_val("hold_instr", instr, 32'h0010_0093);
            check_val("hold_noreq", 32'(fetch_req), 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        check_val("hold_release", 32'(instr_valid), 32'd0);
        do_fetch(32'h108, 32'h0020_0113);

        // BNE taken flushes buffered instruction; same op not taken is ignored
        halt = 1'b1; instr_ready = 1'b0;
        br(3'd1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'hFFFF_FFF8);
        check_val("bne_redirect", 32'(redirect), 32'd1);
        check_val("bne_flush", 32'(instr_valid), 32'd0);
        check_val("bne_addr", fetch_addr, 32'h1F8);
        check_val("bne_notrap", 32'(trap_valid), 32'd0);
        tick();
        check_val("redirect_pulse", 32'(redirect), 32'd0);
        br(3'd1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hFFFF_FFF8);
        check_val("bne_nt_redirect", 32'(redirect), 32'd0);
        check_val("bne_nt_addr", fetch_addr, 32'h1F8);
        halt = 1'b0; instr_ready = 1'b1;
        do_fetch(32'h1F8, 32'h1111_1111);
        halt = 1'b1;
        tick();
        check_val("halt_noreq", 32'(fetch_req), 32'd0);

        // JALR clears bit 0; BLTU/BGEU use the unsigned flag only
        br(3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h301, 32'h4);
        check_val("jalr_redirect", 32'(redirect), 32'd1);
        check_val("jalr_addr", fetch_addr, 32'h304);
        br(3'd6, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h10);
        check_val("bltu_nt", 32'(redirect), 32'd0);
        check_val("bltu_addr", fetch_addr, 32'h304);
        br(3'd7, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h10);
        check_val("bgeu_t", 32'(redirect), 32'd1);
        check_val("bgeu_addr", fetch_addr, 32'h510);

        // Redirect with a request outstanding: late ack data is dropped
        halt = 1'b0;
        wait_req();
        check_val("fetch_addr_510", fetch_addr, 32'h510);
        br(3'd0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h20);
        check_val("kill_redirect", 32'(redirect), 32'd1);
        check_val("kill_req_held", 32'(fetch_req), 32'd1);
        check_val("kill_addr_stable", fetch_addr, 32'h510);
        tick();
        tick();
        check_val("kill_wait_ivalid", 32'(instr_valid), 32'd0);
        fetch_ack = 1'b1; fetch_data = 32'hDEAD_BEEF;
        tick();
        fetch_ack = 1'b0;
        check_val("kill_dropped", 32'(instr_valid), 32'd0);
        check_val("kill_refetch", 32'(fetch_req), 32'd1);
        check_val("kill_target", fetch_addr, 32'h620);
        do_fetch(32'h620, 32'h2222_2222);
        tick();
        wait_req();
        check_val("fetch_addr_624", fetch_addr, 32'h624);

        // Ack coinciding with a redirect: redirect wins
        fetch_ack = 1'b1; fetch_data = 32'hCAFE_F00D;
        br(3'd2, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0, 32'h40);
        fetch_ack = 1'b0;
        check_val("coinc_redirect", 32'(redirect), 32'd1);
        check_val("coinc_dropped", 32'(instr_valid), 32'd0);
        check_val("coinc_addr", fetch_addr, 32'h740);
        do_fetch(32'h740, 32'h3333_3333);
        tick();
        wait_req();
        check_val("fetch_addr_744", fetch_addr, 32'h744);

        // Misaligned JAL target traps; in-flight request completes, then fetch stops
        br(3'd2, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h2);
        check_val("trap_valid", 32'(trap_valid), 32'd1);
        check_val("trap_addr", trap_addr, 32'h402);
        check_val("trap_noredir", 32'(redirect), 32'd0);
        check_val("trap_req_held", 32'(fetch_req), 32'd1);
        tick();
        check_val("trap_pulse", 32'(trap_valid), 32'd0);
        fetch_ack = 1'b1; fetch_data = 32'h4444_4444;
        tick();
        fetch_ack = 1'b0;
        check_val("trap_ack_noreq", 32'(fetch_req), 32'd0);
        check_val("trap_ack_dropped", 32'(instr_valid), 32'd0);
        br(3'd0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 32'h0);
        check_val("trapped_ignore_br", 32'(redirect), 32'd0);
        tick(); tick(); tick();
        check_val("trapped_noreq", 32'(fetch_req), 32'd0);
        check_val("trapped_addr_hold", trap_addr, 32'h402);

        // Async reset, then reset mid-fetch
        nRST = 1'b0;
        #1;
        check_val("rst2_trap_addr", trap_addr, 32'h0);
        check_val("rst2_addr", fetch_addr, 32'h100);
        tick();
        nRST = 1'b1;
        tick();
        check_val("rst2_req", 32'(fetch_req), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_val("rst3_req", 32'(fetch_req), 32'd0);
        check_val("rst3_addr", fetch_addr, 32'h100);
        check_val("rst3_ivalid", 32'(instr_valid), 32'd0);
        nRST = 1'b1;
        tick();
        check_val("rst3_req_again", 32'(fetch_req), 32'd1);
        check_val("rst3_addr_again", fetch_addr, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and fetch sequencer for the RV32 core.
- Owns the architectural fetch PC and issues one outstanding instruction fetch at a time over a req/ack handshake.
- Buffers the returned instruction for decode.
- Applies taken-branch/jump redirects resolved in execute: signed/unsigned compares, JAL/JALR, byte-granular immediates.
- Detects misaligned targets, raising a trap and stopping fetch.

Parameters:
XLEN, 32, width of PC, targets and immediates
INITPC, 32'h0000_0000, PC loaded on reset (XLEN bits)
IMM_SHIFT, 0, left shift applied to br_offset before addition (0 = byte offsets, RISC-V native)

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
fetch_req  out  1  fetch request to instruction memory
fetch_addr  out  XLEN  fetch address; stable while fetch_req high
fetch_ack  in  1  memory returns fetch_data this cycle; completes the request
fetch_data  in  32  instruction word
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr  out  32  buffered instruction
instr_pc  out  XLEN  address of buffered instruction
instr_ready  in  1  decode accepts instr this cycle
halt  in  1  suppress issue of new fetches
br_valid  in  1  execute presents a resolved control-transfer op
br_op  in  3  0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU, 2 JAL, 3 JALR
br_eq  in  1  rs1 == rs2
br_lt  in  1  rs1 < rs2, signed
br_ltu  in  1  rs1 < rs2, unsigned
br_pc  in  XLEN  PC of the control-transfer instruction
br_base  in  XLEN  rs1 value, used by JALR
br_offset  in  XLEN  sign-extended immediate
redirect  out  1  one-cycle pulse: taken redirect applied
trap_valid  out  1  one-cycle pulse: misaligned target detected
trap_addr  out  XLEN  offending target; holds until next trap or reset

Behaviour:
Reset (async, nRST=0):
- PC=INITPC; state=FETCH.
- fetch_req, instr_valid, redirect, trap_valid = 0.
- instr, instr_pc, trap_addr = 0; kill flag = 0.
- fetch_req rises the first cycle after reset release.

States: FETCH, HOLD, TRAPPED.
- FETCH:
  - fetch_req = ~halt, or 1 if a request is already in flight. Requests are never withdrawn before fetch_ack.
  - fetch_addr = PC.
  - On fetch_ack with kill=0: next cycle instr=fetch_data, instr_pc=PC, instr_valid=1, PC=PC+4 (mod 2^XLEN), state=HOLD. Latency ack->instr_valid = 1 cycle.
  - On fetch_ack with kill=1: discard data, clear kill, stay in FETCH.
- HOLD:
  - fetch_req=0.
  - When instr_valid & instr_ready: instr_valid=0 next cycle, state=FETCH.
  - halt does not affect a buffered instruction.

Branch resolution (combinational off br_* inputs, registered effect):
- taken = BEQ:br_eq, BNE:~br_eq, BLT:br_lt, BGE:~br_lt, BLTU:br_ltu, BGEU:~br_ltu, JAL/JALR:1.
- target:
  - JALR: (br_base + (br_offset<<IMM_SHIFT)) & ~1.
  - Otherwise: br_pc + (br_offset<<IMM_SHIFT).
  - All arithmetic XLEN-bit wrap.
- Not taken: no effect.
- Taken with target[1:0]==0:
  - Next cycle PC=target, redirect=1, instr_valid=0 (buffer flushed), state=FETCH.
  - If a request is in flight without ack this cycle, set kill=1.
  - If fetch_ack coincides with the redirect, the returned data is discarded and PC+4 is not applied; the redirect wins.
- Taken with target[1:0]!=0:
  - Next cycle trap_valid=1, trap_addr=target, instr_valid=0, state=TRAPPED.
  - PC is unchanged.
  - Any in-flight request completes and its data is discarded.
- TRAPPED: fetch_req=0 once the in-flight request is acked; further br_valid is ignored. Exit only via reset.
- br_valid is honoured in every state except TRAPPED.
- redirect and trap_valid are never high in the same cycle.

Test Plan:
- Reset with INITPC=32'h100, halt=0, ack 1 cycle after each req, instr_ready=1 -> fetch_addr sequence 100,104,108; instr_pc matches; instr_valid 1 cycle after each ack.
- Buffered instr at pc 104, instr_ready=0 for 5 cycles -> instr/instr_pc held, fetch_req=0; ready high -> next fetch at 108.
- BNE with br_eq=0, br_pc=200, br_offset=-8 -> redirect pulse, next fetch_addr=1F8, buffer flushed; same op with br_eq=1 -> no change.
- JALR with br_base=301, offset=4 -> target 304. JAL with br_pc=400, offset=2 -> trap_valid pulse, trap_addr=402, no further fetch_req.
- Redirect while req outstanding (ack delayed 3 cycles) -> ack data dropped (instr_valid stays 0), then fetch_addr=target. Repeat with ack in the same cycle as br_valid -> data dropped.
- BLTU/BGEU with br_lt=1, br_ltu=0 -> BLTU not taken, BGEU taken. nRST pulsed mid-fetch -> all outputs to reset values immediately, PC=INITPC.
